sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 128 ++++++++++++
 tb/tb_sync_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO, any DEPTH >= 2, with occupancy count and programmable almost-full/almost-empty thresholds.
// Latency: a write is readable one edge later; dout and rd_valid are registered one cycle after the read is accepted.
// Backpressure: writes are refused at full unless a read is accepted in the same cycle; reads are refused at empty.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] din,
  input  logic             read_en,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_acc, wr_acc;
  logic             empty_w, full_w;

  // Flags come straight from the count register so they only move on clock edges.
  always_comb begin
    empty_w      = (count_q == '0);
    full_w       = (count_q == CW'(DEPTH));
    empty        = empty_w;
    full         = full_w;
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
    count        = count_q;
    dout         = dout_q;
    rd_valid     = rd_valid_q;
  end

  // Accept logic, pointer wrap at DEPTH-1, occupancy and read-data next state.
  always_comb begin
    rd_acc     = read_en && !empty_w;
    // A read accepted at full frees a slot, so the write may proceed alongside it.
    wr_acc     = write_en && (!full_w || rd_acc);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      dout_d = mem_q[rptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; queued data is discarded on a reset edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array; contents are not cleared by reset, and writes during reset are ignored.
  always_ff @(posedge CLK) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q] <= din;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set by any refused request, cleared only by reset.
  always_comb begin
    overflow_d  = overflow_q  | (write_en && !wr_acc);
    underflow_d = underflow_q | (read_en && empty_w);
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

  // Error flag registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at DEPTH=5, WIDTH=16, AF_LEVEL=4, AE_LEVEL=1.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Error-flag checks are compiled in only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

  localparam int DEPTH = 5;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             CLK;
  logic             rst;
  logic             write_en;
  logic [WIDTH-1:0] din;
  logic             read_en;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int total = 0;
  int bad   = 0;

  sync_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .write_en(write_en),
    .din(din),
    .read_en(read_en),
    .dout(dout),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    write_en = 1'b1; read_en = 1'b0; din = d;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; din = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_dout", dout, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
`endif

    // Fill 1..5 with flag thresholds
    for (int i = 1; i <= 5; i++) begin
      push(16'(i));
      chk("fill_count", count, i);
      chk("fill_empty", empty, 0);
      chk("fill_ae", almost_empty, (i <= 1) ? 1 : 0);
      chk("fill_af", almost_full, (i >= 4) ? 1 : 0);
      chk("fill_full", full, (i == 5) ? 1 : 0);
    end

    // Drain 5 back-to-back
    read_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("drain_dout", dout, i);
      chk("drain_rdv", rd_valid, 1);
      chk("drain_count", count, 5 - i);
    end
    read_en = 1'b0;
    chk("drain_empty", empty, 1);
    tick();
    chk("idle_rdv", rd_valid, 0);
    chk("idle_dout_hold", dout, 16'h0005);

    // Simultaneous read and write at full
    for (int i = 0; i < 5; i++) push(16'h0011 + 16'(i));
    write_en = 1'b1; read_en = 1'b1; din = 16'hBEEF;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("rwfull_count", count, 5);
    chk("rwfull_full", full, 1);
    chk("rwfull_dout", dout, 16'h0011);
    chk("rwfull_rdv", rd_valid, 1);
    read_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rwfull_drain", dout, (i < 4) ? 16'h0012 + 16'(i) : 16'hBEEF);
      if (i == 0) chk("full_deassert", full, 0);
    end
    read_en = 1'b0;
    chk("rwfull_empty", empty, 1);

    // Simultaneous read and write at empty
    write_en = 1'b1; read_en = 1'b1; din = 16'h00AA;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("rwempty_rdv", rd_valid, 0);
    chk("rwempty_count", count, 1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("rwempty_dout", dout, 16'h00AA);
    chk("rwempty_rdv2", rd_valid, 1);
    chk("rwempty_count2", count, 0);

    // Wrap: alternate write then read, 12 cycles
    for (int k = 0; k < 6; k++) begin
      push(16'h0100 + 16'(k));
      chk("wrap_count_w", count, 1);
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      chk("wrap_dout", dout, 16'h0100 + 16'(k));
      chk("wrap_rdv", rd_valid, 1);
    end

    // Read at empty
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("udf_count", count, 0);
    chk("udf_rdv", rd_valid, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_flag", underflow, 1);
    chk("udf_no_ovf", overflow, 0);
`endif

    // Write at full without a read
    for (int i = 0; i < 5; i++) push(16'h0201 + 16'(i));
    push(16'hDEAD);
    chk("ovf_count", count, 5);
    chk("ovf_full", full, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", overflow, 1);
`endif

    // Read two, leaving 3 words
    read_en = 1'b1;
    tick();
    chk("part_dout0", dout, 16'h0201);
    tick();
    read_en = 1'b0;
    chk("part_dout1", dout, 16'h0202);
    chk("part_count", count, 3);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_persist", overflow, 1);
    chk("udf_persist", underflow, 1);
`endif

    // Reset mid-operation with a write request
    rst = 1'b1; write_en = 1'b1; din = 16'h7777;
    tick();
    rst = 1'b0; write_en = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_dout", dout, 0);
    chk("mrst_rdv", rd_valid, 0);
    chk("mrst_ae", almost_empty, 1);
    chk("mrst_af", almost_full, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("mrst_ovf", overflow, 0);
    chk("mrst_udf", underflow, 0);
`endif
    tick();
    chk("mrst_nowrite", count, 0);

    // Normal operation after reset
    push(16'h0042);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("post_rst_dout", dout, 16'h0042);
    chk("post_rst_rdv", rd_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
